// File: rtl/ps2_key_receiver.sv
// Receive-only PS/2 keyboard front end: deserialises 11-bit frames, checks framing and
// odd parity, and decodes E0/F0 prefixes into key events. Optional macro: PS2_RX_TIMEOUT_EN.
module ps2_key_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_released,
  output logic       key_extended,
  output logic [7:0] raw_byte,
  output logic       raw_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2} state_t;

  state_t        state, state_next;
  logic [SS-1:0] clk_sync, dat_sync;
  logic          clk_prev, fall, bit_in, shift_bit;
  logic          pend, pend_bit;
  logic [3:0]    cnt, cnt_next;
  logic [10:0]   shreg, frame_next;
  logic          shift_en, check_go, timeout;
  logic          ext, brk;

  function automatic logic parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  function automatic logic framing_ok(input logic [10:0] f);
    return !f[0] && f[10];
  endfunction

  // Input conditioning: synchronisers and falling-edge detect, idle level is 1
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SS-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SS-2:0], PS2_DAT};
      clk_prev <= clk_sync[SS-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SS-1];
  assign bit_in = dat_sync[SS-1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign timeout = (state == SHIFT) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state != SHIFT || fall || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // An edge seen during CHECK is parked in pend and replayed as the start bit in IDLE
  assign shift_bit  = (state == IDLE && pend) ? pend_bit : bit_in;
  assign frame_next = {shift_bit, shreg[10:1]};

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_en   = 1'b0;
    check_go   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall || pend) begin
          state_next = SHIFT;
          cnt_next   = 4'd1;
          shift_en   = 1'b1;
        end
      end
      SHIFT: begin
        if (fall) begin
          shift_en = 1'b1;
          cnt_next = cnt + 4'd1;
          if (cnt == 4'd10) begin
            state_next = CHECK;
            check_go   = 1'b1;
          end
        end else if (timeout) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      end
      CHECK: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Frame FSM state, bit counter and shift register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      shreg    <= '0;
      pend     <= 1'b0;
      pend_bit <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (shift_en) shreg <= frame_next;
      if (state == CHECK && fall) begin
        pend     <= 1'b1;
        pend_bit <= bit_in;
      end else if (state == IDLE) begin
        pend <= 1'b0;
      end
    end
  end

  // Frame check (registered on the stop-bit edge) and prefix decoder one cycle later
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      raw_byte     <= 8'h00;
      raw_valid    <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      key_code     <= 8'h00;
      key_valid    <= 1'b0;
      key_released <= 1'b0;
      key_extended <= 1'b0;
      ext          <= 1'b0;
      brk          <= 1'b0;
    end else begin
      raw_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= timeout;
      key_valid  <= 1'b0;
      if (check_go) begin
        if (!framing_ok(frame_next)) begin
          frame_err <= 1'b1;
        end else if (!parity_ok(frame_next[9:1])) begin
          parity_err <= 1'b1;
        end else begin
          raw_valid <= 1'b1;
          raw_byte  <= frame_next[8:1];
        end
      end
      if (raw_valid) begin
        if (raw_byte == 8'hE0) begin
          ext <= 1'b1;
        end else if (raw_byte == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          key_code     <= raw_byte;
          key_extended <= ext;
          key_released <= brk;
          key_valid    <= 1'b1;
          ext          <= 1'b0;
          brk          <= 1'b0;
        end
      end else if (parity_err || frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Scoreboard bench for ps2_key_receiver: a byte-level keyboard model predicts raw bytes,
// error pulses and decoded key events; a monitor compares whatever the DUT presents.
module tb_ps2_key_receiver;

  localparam int HALF = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [7:0] key_code, raw_byte;
  logic       key_valid, key_released, key_extended;
  logic       raw_valid, parity_err, frame_err;

  ps2_key_receiver #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(50000)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .key_code(key_code), .key_valid(key_valid), .key_released(key_released),
    .key_extended(key_extended), .raw_byte(raw_byte), .raw_valid(raw_valid),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] raw_q[$];
  logic [7:0] err_q[$];
  logic [9:0] key_q[$];
  bit         m_ext = 1'b0, m_brk = 1'b0;
  bit         chk_zero = 1'b0, chk_empty = 1'b0;
  logic       prev_raw = 1'b0;
  logic [7:0] eb;
  logic [9:0] ek;

  // Monitor: every output pulse pops its queue; requested snapshot checks also run here
  always @(negedge CLOCK_50) begin
    if (chk_zero) begin
      checks++;
      if ({key_code, key_valid, key_released, key_extended, raw_byte, raw_valid, parity_err, frame_err} !== 22'h0) begin
        errors++;
        $display("FAIL reset_outputs got %h want 0",
                 {key_code, key_valid, key_released, key_extended, raw_byte, raw_valid, parity_err, frame_err});
      end
    end
    if (chk_empty) begin
      checks++;
      if (raw_q.size() + err_q.size() + key_q.size() != 0) begin
        errors++;
        $display("FAIL leftover got raw=%0d err=%0d key=%0d want 0 0 0", raw_q.size(), err_q.size(), key_q.size());
      end
    end
    if (!reset) begin
      if (raw_valid) begin
        checks++;
        if (raw_q.size() == 0) begin
          errors++; $display("FAIL raw_unexpected got %h want no byte", raw_byte);
        end else begin
          eb = raw_q.pop_front();
          if (raw_byte !== eb) begin errors++; $display("FAIL raw_byte got %h want %h", raw_byte, eb); end
        end
      end
      if (parity_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++; $display("FAIL parity_unexpected got pulse want none");
        end else begin
          eb = err_q.pop_front();
          if (eb !== 8'h50) begin errors++; $display("FAIL err_kind got P want %c", eb); end
        end
      end
      if (frame_err) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++; $display("FAIL frame_unexpected got pulse want none");
        end else begin
          eb = err_q.pop_front();
          if (eb !== 8'h46) begin errors++; $display("FAIL err_kind got F want %c", eb); end
        end
      end
      if (key_valid) begin
        checks++;
        if (prev_raw !== 1'b1) begin
          errors++; $display("FAIL key_latency got raw_valid_prev=%b want 1", prev_raw);
        end
        checks++;
        if (key_q.size() == 0) begin
          errors++; $display("FAIL key_unexpected got %h want no key", key_code);
        end else begin
          ek = key_q.pop_front();
          if ({key_code, key_extended, key_released} !== ek) begin
            errors++;
            $display("FAIL key_event got code=%h ext=%b rel=%b want code=%h ext=%b rel=%b",
                     key_code, key_extended, key_released, ek[9:2], ek[1], ek[0]);
          end
        end
      end
      prev_raw = raw_valid;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Keyboard-level reference: what the game logic should see for one transmitted byte
  task automatic model_frame(input logic [7:0] b, input int kind);
    if (kind == 1) begin
      err_q.push_back(8'h50); m_ext = 1'b0; m_brk = 1'b0;
    end else if (kind != 0) begin
      err_q.push_back(8'h46); m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      raw_q.push_back(b);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        key_q.push_back({b, m_ext, m_brk});
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end
  endtask

  task automatic send_bit(input logic v);
    PS2_DAT = v;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  // kind: 0 good, 1 parity flipped, 2 stop bit 0, 3 start bit 1
  function automatic logic [10:0] build_frame(input logic [7:0] b, input int kind);
    logic par;
    par = ~(^b);
    if (kind == 1) par = ~par;
    return {(kind == 2) ? 1'b0 : 1'b1, par, b, (kind == 3) ? 1'b1 : 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f = build_frame(b, kind);
    model_frame(b, kind);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    PS2_DAT = 1'b1;
    wait_cyc(4 * HALF);
  endtask

  task automatic check_zero_now();
    @(posedge CLOCK_50) chk_zero = 1'b1;
    @(posedge CLOCK_50) chk_zero = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(4);
    check_zero_now();
    wait_cyc(1);
    reset = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0;
    wait_cyc(10);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  b;
    int          kind;

    do_reset();

    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'h29, 1); send_frame(8'h29, 0);
    send_frame(8'h1C, 2);
    send_frame(8'h6B, 3);

    f = build_frame(8'h1C, 0);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    wait_cyc(HALF);
    do_reset();
    send_frame(8'h1C, 0);

`ifdef PS2_RX_TIMEOUT_EN
    err_q.push_back(8'h46); m_ext = 1'b0; m_brk = 1'b0;
    f = build_frame(8'h33, 0);
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    wait_cyc(50100);
    send_frame(8'h5A, 0);
`endif

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 5))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      kind = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      send_frame(b, kind);
    end

    wait_cyc(50);
    @(posedge CLOCK_50) chk_empty = 1'b1;
    @(posedge CLOCK_50) chk_empty = 1'b0;
    wait_cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
